// File: rtl/lsu_lq_ordered.sv
// rtl/lsu_lq_ordered.sv - ordered load queue with miss replay and store-overlap mis-speculation detection
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_flush                      invalidate every slot
//   i_rob_head_tag               oldest in-flight ROB tag, reference point for ages
//   o_full                       no free slot (state based)
//   i_alloc_*                    allocate a load into the lowest free slot
//   i_replay_stall, o_replay_*   oldest replay-ready load issued back to LSU_EX
//   i_update_lq_*                mark the last allocated/replayed load as waiting on the MHQ
//   i_mhq_fill*                  MHQ fill broadcast
//   i_sq_retire_*                retiring store, checked against younger loads
//   i_rob_retire_*               retiring load, o_rob_retire_mis_speculated reports its flag

package procyon_pkg;
    typedef enum logic [2:0] {
        LSU_FUNC_LB  = 3'd0,
        LSU_FUNC_LH  = 3'd1,
        LSU_FUNC_LW  = 3'd2,
        LSU_FUNC_LBU = 3'd3,
        LSU_FUNC_LHU = 3'd4,
        LSU_FUNC_SB  = 3'd5,
        LSU_FUNC_SH  = 3'd6,
        LSU_FUNC_SW  = 3'd7
    } procyon_lsu_func_t;
endpackage

module lsu_lq_ordered
    import procyon_pkg::*;
#(
    parameter int LQ_DEPTH      = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int ROB_TAG_WIDTH = 6,
    parameter int MHQ_TAG_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic [ROB_TAG_WIDTH-1:0] i_rob_head_tag,
    output logic                     o_full,
    input  logic                     i_alloc_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_alloc_tag,
    input  logic [ADDR_WIDTH-1:0]    i_alloc_addr,
    input  procyon_lsu_func_t        i_alloc_lsu_func,
    input  logic                     i_replay_stall,
    output logic                     o_replay_en,
    output logic [ROB_TAG_WIDTH-1:0] o_replay_tag,
    output logic [ADDR_WIDTH-1:0]    o_replay_addr,
    output procyon_lsu_func_t        o_replay_lsu_func,
    input  logic                     i_update_lq_en,
    input  logic                     i_update_lq_retry,
    input  logic [MHQ_TAG_WIDTH-1:0] i_update_lq_mhq_tag,
    input  logic                     i_mhq_fill,
    input  logic [MHQ_TAG_WIDTH-1:0] i_mhq_fill_tag,
    input  logic                     i_sq_retire_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_sq_retire_tag,
    input  logic [ADDR_WIDTH-1:0]    i_sq_retire_addr,
    input  procyon_lsu_func_t        i_sq_retire_lsu_func,
    input  logic                     i_rob_retire_en,
    input  logic [ROB_TAG_WIDTH-1:0] i_rob_retire_tag,
    output logic                     o_rob_retire_mis_speculated
);

    localparam int IDX_W = $clog2(LQ_DEPTH);

    logic [LQ_DEPTH-1:0]      valid;
    logic [LQ_DEPTH-1:0]      needs_replay;
    logic [LQ_DEPTH-1:0]      replay_rdy;
    logic [LQ_DEPTH-1:0]      replay_retry;
    logic [LQ_DEPTH-1:0]      mis_spec;
    logic [ROB_TAG_WIDTH-1:0] tag      [LQ_DEPTH];
    logic [ADDR_WIDTH-1:0]    addr     [LQ_DEPTH];
    procyon_lsu_func_t        lsu_func [LQ_DEPTH];
    logic [MHQ_TAG_WIDTH-1:0] mhq_tag  [LQ_DEPTH];
    logic [IDX_W-1:0]         update_slot;

    function automatic logic [2:0] func_size(input procyon_lsu_func_t f);
        case (f)
            LSU_FUNC_LB, LSU_FUNC_LBU, LSU_FUNC_SB: func_size = 3'd1;
            LSU_FUNC_LH, LSU_FUNC_LHU, LSU_FUNC_SH: func_size = 3'd2;
            default:                                func_size = 3'd4;
        endcase
    endfunction

    // Ages relative to the ROB head; unsigned wrap gives the modulo for free.
    logic [ROB_TAG_WIDTH-1:0] age [LQ_DEPTH];
    logic [ROB_TAG_WIDTH-1:0] st_age;
    logic [ADDR_WIDTH:0]      st_start;
    logic [ADDR_WIDTH:0]      st_end;
    logic [LQ_DEPTH-1:0]      st_hit;

    always_comb begin
        st_age   = i_sq_retire_tag - i_rob_head_tag;
        st_start = {1'b0, i_sq_retire_addr};
        st_end   = st_start + (ADDR_WIDTH+1)'(func_size(i_sq_retire_lsu_func));
        for (int i = 0; i < LQ_DEPTH; i++) begin
            logic [ADDR_WIDTH:0] ld_start;
            logic [ADDR_WIDTH:0] ld_end;
            age[i]    = tag[i] - i_rob_head_tag;
            ld_start  = {1'b0, addr[i]};
            ld_end    = ld_start + (ADDR_WIDTH+1)'(func_size(lsu_func[i]));
            // Only loads that already returned data and are younger than the store can be wrong.
            st_hit[i] = valid[i] && !needs_replay[i] && (age[i] > st_age) &&
                        (ld_start < st_end) && (st_start < ld_end);
        end
    end

    // Lowest-index free slot.
    logic [IDX_W-1:0] alloc_slot;
    logic             alloc_accept;

    always_comb begin
        alloc_slot = '0;
        for (int i = LQ_DEPTH-1; i >= 0; i--) begin
            if (!valid[i]) alloc_slot = IDX_W'(i);
        end
    end

    assign o_full       = &valid;
    assign alloc_accept = i_alloc_en && !o_full && !i_flush;

    // Oldest replay-ready slot.
    logic                     rp_found;
    logic [IDX_W-1:0]         rp_slot;
    logic [ROB_TAG_WIDTH-1:0] rp_age;

    always_comb begin
        rp_found = 1'b0;
        rp_slot  = '0;
        rp_age   = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (replay_rdy[i] && (!rp_found || age[i] < rp_age)) begin
                rp_found = 1'b1;
                rp_slot  = IDX_W'(i);
                rp_age   = age[i];
            end
        end
    end

    // An allocation owns the LSU_EX port this cycle, even if it is not accepted.
    assign o_replay_en       = rp_found && !i_replay_stall && !i_alloc_en;
    assign o_replay_tag      = tag[rp_slot];
    assign o_replay_addr     = addr[rp_slot];
    assign o_replay_lsu_func = lsu_func[rp_slot];

    always_comb begin
        o_rob_retire_mis_speculated = 1'b0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (valid[i] && tag[i] == i_rob_retire_tag && mis_spec[i]) begin
                o_rob_retire_mis_speculated = 1'b1;
            end
        end
    end

    // A fill arriving in the same cycle as the update would otherwise be missed,
    // leaving the load waiting forever.
    logic update_fill_hit;
    assign update_fill_hit = i_mhq_fill &&
                             (i_update_lq_retry || i_mhq_fill_tag == i_update_lq_mhq_tag);

    // Per-slot actions are written lowest priority first so later ones override.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid        <= '0;
            needs_replay <= '0;
            replay_rdy   <= '0;
            replay_retry <= '0;
            mis_spec     <= '0;
            update_slot  <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                tag[i]      <= '0;
                addr[i]     <= '0;
                lsu_func[i] <= LSU_FUNC_LB;
                mhq_tag[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) begin
                if (i_mhq_fill && needs_replay[i] && !replay_rdy[i] &&
                    (replay_retry[i] || mhq_tag[i] == i_mhq_fill_tag)) begin
                    replay_rdy[i] <= 1'b1;
                end
                if (i_sq_retire_en && st_hit[i]) begin
                    mis_spec[i] <= 1'b1;
                end
                if (i_rob_retire_en && valid[i] && tag[i] == i_rob_retire_tag) begin
                    valid[i] <= 1'b0;
                end
                if (o_replay_en && rp_slot == IDX_W'(i)) begin
                    needs_replay[i] <= 1'b0;
                    replay_rdy[i]   <= 1'b0;
                end
                if (i_update_lq_en && update_slot == IDX_W'(i)) begin
                    needs_replay[i] <= 1'b1;
                    replay_retry[i] <= i_update_lq_retry;
                    mhq_tag[i]      <= i_update_lq_mhq_tag;
                    mis_spec[i]     <= 1'b0;
                    replay_rdy[i]   <= update_fill_hit;
                end
                if (alloc_accept && alloc_slot == IDX_W'(i)) begin
                    valid[i]        <= 1'b1;
                    tag[i]          <= i_alloc_tag;
                    addr[i]         <= i_alloc_addr;
                    lsu_func[i]     <= i_alloc_lsu_func;
                    needs_replay[i] <= 1'b0;
                    replay_rdy[i]   <= 1'b0;
                    mis_spec[i]     <= 1'b0;
                end
                if (i_flush) begin
                    valid[i]        <= 1'b0;
                    needs_replay[i] <= 1'b0;
                    replay_rdy[i]   <= 1'b0;
                end
            end

            if (alloc_accept) begin
                update_slot <= alloc_slot;
            end else if (o_replay_en) begin
                update_slot <= rp_slot;
            end
        end
    end

endmodule

// File: tb/tb_lsu_lq_ordered.sv
// tb/tb_lsu_lq_ordered.sv - self-checking bench for lsu_lq_ordered
module tb_lsu_lq_ordered;
    import procyon_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_flush;
    logic [5:0]        i_rob_head_tag;
    logic              o_full;
    logic              i_alloc_en;
    logic [5:0]        i_alloc_tag;
    logic [31:0]       i_alloc_addr;
    procyon_lsu_func_t i_alloc_lsu_func;
    logic              i_replay_stall;
    logic              o_replay_en;
    logic [5:0]        o_replay_tag;
    logic [31:0]       o_replay_addr;
    procyon_lsu_func_t o_replay_lsu_func;
    logic              i_update_lq_en;
    logic              i_update_lq_retry;
    logic [1:0]        i_update_lq_mhq_tag;
    logic              i_mhq_fill;
    logic [1:0]        i_mhq_fill_tag;
    logic              i_sq_retire_en;
    logic [5:0]        i_sq_retire_tag;
    logic [31:0]       i_sq_retire_addr;
    procyon_lsu_func_t i_sq_retire_lsu_func;
    logic              i_rob_retire_en;
    logic [5:0]        i_rob_retire_tag;
    logic              o_rob_retire_mis_speculated;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_lq_ordered #(
        .LQ_DEPTH(8), .ADDR_WIDTH(32), .ROB_TAG_WIDTH(6), .MHQ_TAG_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_rob_head_tag(i_rob_head_tag),
        .o_full(o_full),
        .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
        .i_alloc_lsu_func(i_alloc_lsu_func),
        .i_replay_stall(i_replay_stall), .o_replay_en(o_replay_en), .o_replay_tag(o_replay_tag),
        .o_replay_addr(o_replay_addr), .o_replay_lsu_func(o_replay_lsu_func),
        .i_update_lq_en(i_update_lq_en), .i_update_lq_retry(i_update_lq_retry),
        .i_update_lq_mhq_tag(i_update_lq_mhq_tag),
        .i_mhq_fill(i_mhq_fill), .i_mhq_fill_tag(i_mhq_fill_tag),
        .i_sq_retire_en(i_sq_retire_en), .i_sq_retire_tag(i_sq_retire_tag),
        .i_sq_retire_addr(i_sq_retire_addr), .i_sq_retire_lsu_func(i_sq_retire_lsu_func),
        .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
        .o_rob_retire_mis_speculated(o_rob_retire_mis_speculated)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        i_flush = 0; i_alloc_en = 0; i_alloc_tag = 0; i_alloc_addr = 0;
        i_alloc_lsu_func = LSU_FUNC_LB; i_replay_stall = 0;
        i_update_lq_en = 0; i_update_lq_retry = 0; i_update_lq_mhq_tag = 0;
        i_mhq_fill = 0; i_mhq_fill_tag = 0;
        i_sq_retire_en = 0; i_sq_retire_tag = 0; i_sq_retire_addr = 0;
        i_sq_retire_lsu_func = LSU_FUNC_SB; i_rob_retire_en = 0; i_rob_retire_tag = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs(); i_rob_head_tag = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic alloc(input logic [5:0] t, input logic [31:0] a, input procyon_lsu_func_t f);
        i_alloc_en = 1; i_alloc_tag = t; i_alloc_addr = a; i_alloc_lsu_func = f;
        nxt();
        i_alloc_en = 0;
    endtask

    task automatic upd(input logic retry, input logic [1:0] m, input logic fill, input logic [1:0] ft);
        i_update_lq_en = 1; i_update_lq_retry = retry; i_update_lq_mhq_tag = m;
        i_mhq_fill = fill; i_mhq_fill_tag = ft;
        nxt();
        i_update_lq_en = 0; i_mhq_fill = 0;
    endtask

    task automatic store(input logic [5:0] t, input logic [31:0] a, input procyon_lsu_func_t f);
        i_sq_retire_en = 1; i_sq_retire_tag = t; i_sq_retire_addr = a; i_sq_retire_lsu_func = f;
        nxt();
        i_sq_retire_en = 0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst = 1; clear_inputs(); i_rob_head_tag = 0;
        @(negedge clk);
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", o_full); end
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL reset_replay_en: got %0b expected 0", o_replay_en); end
        n_tests++; if (o_rob_retire_mis_speculated !== 1'b0) begin n_fail++; $display("FAIL reset_mis_spec: got %0b expected 0", o_rob_retire_mis_speculated); end
        nxt(); rst = 0;
        @(negedge clk);
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL post_reset_full: got %0b expected 0", o_full); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 7; i++) alloc(6'(i), 32'(i * 4), LSU_FUNC_LW);
        @(negedge clk);
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL full_after_7: got %0b expected 0", o_full); end
        nxt(); alloc(6'd7, 32'h1C, LSU_FUNC_LW);
        @(negedge clk);
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_after_8: got %0b expected 1", o_full); end
        nxt();
        i_rob_retire_en = 1; i_rob_retire_tag = 6'd3;
        @(negedge clk);
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_during_retire: got %0b expected 1", o_full); end
        nxt(); i_rob_retire_en = 0;
        @(negedge clk);
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL full_after_retire: got %0b expected 0", o_full); end
        nxt(); alloc(6'd20, 32'h3C0, LSU_FUNC_LHU);
        @(negedge clk);
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_after_refill: got %0b expected 1", o_full); end
        nxt(); upd(1'b1, 2'd0, 1'b1, 2'd0);
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b1) begin n_fail++; $display("FAIL refill_replay_en: got %0b expected 1", o_replay_en); end
        n_tests++; if (o_replay_tag !== 6'd20) begin n_fail++; $display("FAIL refill_replay_tag: got %0d expected 20", o_replay_tag); end
        n_tests++; if (o_replay_addr !== 32'h3C0) begin n_fail++; $display("FAIL refill_replay_addr: got %0h expected 3c0", o_replay_addr); end
        n_tests++; if (o_replay_lsu_func !== LSU_FUNC_LHU) begin n_fail++; $display("FAIL refill_replay_func: got %0d expected %0d", o_replay_lsu_func, LSU_FUNC_LHU); end
    endtask

    task automatic test_replay_order();
        int exp_order [3] = '{2, 5, 9};
        do_reset();
        alloc(6'd5, 32'h500, LSU_FUNC_LW); upd(1'b0, 2'd1, 1'b0, 2'd0);
        alloc(6'd2, 32'h200, LSU_FUNC_LB); upd(1'b0, 2'd1, 1'b0, 2'd0);
        alloc(6'd9, 32'h900, LSU_FUNC_LH); upd(1'b0, 2'd1, 1'b0, 2'd0);
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL order_before_fill: got %0b expected 0", o_replay_en); end
        nxt(); i_mhq_fill = 1; i_mhq_fill_tag = 2'd3;
        nxt(); i_mhq_fill = 0;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL order_wrong_fill: got %0b expected 0", o_replay_en); end
        nxt(); i_mhq_fill = 1; i_mhq_fill_tag = 2'd1;
        nxt(); i_mhq_fill = 0; i_replay_stall = 1;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL order_stalled: got %0b expected 0", o_replay_en); end
        nxt(); i_replay_stall = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++; if (o_replay_en !== 1'b1 || o_replay_tag !== 6'(exp_order[k])) begin
                n_fail++; $display("FAIL order_replay_%0d: got en=%0b tag=%0d expected en=1 tag=%0d", k, o_replay_en, o_replay_tag, exp_order[k]);
            end
            nxt();
        end
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL order_drained: got %0b expected 0", o_replay_en); end
    endtask

    task automatic test_update_fill_race();
        do_reset();
        alloc(6'd7, 32'h700, LSU_FUNC_LW);
        upd(1'b0, 2'd2, 1'b1, 2'd2);
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b1 || o_replay_tag !== 6'd7) begin
            n_fail++; $display("FAIL race_replay: got en=%0b tag=%0d expected en=1 tag=7", o_replay_en, o_replay_tag);
        end
        nxt();
        alloc(6'd8, 32'h800, LSU_FUNC_LW);
        upd(1'b0, 2'd2, 1'b1, 2'd3);
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL race_other_fill: got %0b expected 0", o_replay_en); end
        nxt(); i_mhq_fill = 1; i_mhq_fill_tag = 2'd2;
        nxt(); i_mhq_fill = 0;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b1 || o_replay_tag !== 6'd8) begin
            n_fail++; $display("FAIL race_late_fill: got en=%0b tag=%0d expected en=1 tag=8", o_replay_en, o_replay_tag);
        end
        nxt();
    endtask

    task automatic retire_check(input logic [5:0] t, input logic exp, input string nm);
        i_rob_retire_en = 1; i_rob_retire_tag = t;
        @(negedge clk);
        n_tests++; if (o_rob_retire_mis_speculated !== exp) begin
            n_fail++; $display("FAIL %s: got %0b expected %0b", nm, o_rob_retire_mis_speculated, exp);
        end
        nxt(); i_rob_retire_en = 0;
    endtask

    task automatic test_mis_spec();
        do_reset();
        alloc(6'd8, 32'h100, LSU_FUNC_LW); store(6'd4, 32'h103, LSU_FUNC_SB);
        retire_check(6'd8, 1'b1, "ms_older_overlap");
        alloc(6'd8, 32'h100, LSU_FUNC_LW); store(6'd9, 32'h103, LSU_FUNC_SB);
        retire_check(6'd8, 1'b0, "ms_younger_store");
        alloc(6'd8, 32'h100, LSU_FUNC_LW); store(6'd4, 32'h104, LSU_FUNC_SB);
        retire_check(6'd8, 1'b0, "ms_adjacent_bytes");
        alloc(6'd8, 32'h100, LSU_FUNC_LW); store(6'd4, 32'h0FE, LSU_FUNC_SW);
        retire_check(6'd8, 1'b1, "ms_low_overlap");
        alloc(6'd8, 32'h100, LSU_FUNC_LW);
        i_update_lq_en = 1; i_update_lq_mhq_tag = 2'd0; i_update_lq_retry = 0;
        store(6'd4, 32'h100, LSU_FUNC_SB);
        i_update_lq_en = 0;
        retire_check(6'd8, 1'b0, "ms_update_wins");
        alloc(6'd10, 32'hFFFF_FFFC, LSU_FUNC_LW); store(6'd4, 32'hFFFF_FFFF, LSU_FUNC_SW);
        retire_check(6'd10, 1'b1, "ms_top_of_space");
    endtask

    task automatic test_wrap();
        do_reset();
        i_rob_head_tag = 6'd60;
        alloc(6'd1, 32'h200, LSU_FUNC_LW); store(6'd62, 32'h200, LSU_FUNC_SW);
        retire_check(6'd1, 1'b1, "wrap_older_store");
        alloc(6'd1, 32'h200, LSU_FUNC_LW); store(6'd3, 32'h200, LSU_FUNC_SW);
        retire_check(6'd1, 1'b0, "wrap_younger_store");
    endtask

    task automatic test_flush();
        do_reset();
        i_replay_stall = 1;
        alloc(6'd1, 32'h10, LSU_FUNC_LW); upd(1'b1, 2'd0, 1'b1, 2'd0);
        alloc(6'd2, 32'h20, LSU_FUNC_LW); upd(1'b1, 2'd0, 1'b1, 2'd0);
        i_replay_stall = 0; i_flush = 1; i_alloc_en = 1; i_alloc_tag = 6'd3;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL flush_cycle_replay: got %0b expected 0", o_replay_en); end
        nxt(); i_flush = 0; i_alloc_en = 0;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL flush_next_replay: got %0b expected 0", o_replay_en); end
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL flush_full: got %0b expected 0", o_full); end
        nxt();
        for (int i = 0; i < 7; i++) alloc(6'(10 + i), 32'h0, LSU_FUNC_LB);
        @(negedge clk);
        n_tests++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL flush_empty_7: got %0b expected 0", o_full); end
        nxt(); alloc(6'd17, 32'h0, LSU_FUNC_LB);
        @(negedge clk);
        n_tests++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL flush_empty_8: got %0b expected 1", o_full); end
        nxt();
    endtask

    task automatic test_async_reset();
        do_reset();
        i_replay_stall = 1;
        alloc(6'd4, 32'h40, LSU_FUNC_LW); upd(1'b1, 2'd0, 1'b1, 2'd0);
        i_replay_stall = 0;
        @(negedge clk);
        n_tests++; if (o_replay_en !== 1'b1) begin n_fail++; $display("FAIL areset_before: got %0b expected 1", o_replay_en); end
        #1 rst = 1;
        #1;
        n_tests++; if (o_replay_en !== 1'b0) begin n_fail++; $display("FAIL areset_replay_drop: got %0b expected 0", o_replay_en); end
        nxt(); rst = 0;
    endtask

    // ---------------- randomized test against a tag-indexed model ----------------
    bit                m_valid [64];
    bit                m_nr    [64];
    bit                m_rdy   [64];
    bit                m_retry [64];
    bit                m_ms    [64];
    logic [31:0]       m_addr  [64];
    procyon_lsu_func_t m_func  [64];
    logic [1:0]        m_mhq   [64];

    function automatic int fsize(input procyon_lsu_func_t f);
        if (f == LSU_FUNC_LB || f == LSU_FUNC_LBU || f == LSU_FUNC_SB) return 1;
        if (f == LSU_FUNC_LH || f == LSU_FUNC_LHU || f == LSU_FUNC_SH) return 2;
        return 4;
    endfunction

    function automatic int age_of(input int t, input int h);
        return (t - h + 64) % 64;
    endfunction

    task automatic test_random();
        for (int ph = 0; ph < 6; ph++) begin
            int head;
            int knext;
            int m_last;
            do_reset();
            for (int t = 0; t < 64; t++) begin
                m_valid[t] = 0; m_nr[t] = 0; m_rdy[t] = 0; m_retry[t] = 0; m_ms[t] = 0;
            end
            head = int'($urandom % 64);
            i_rob_head_tag = 6'(head);
            knext = 1;
            m_last = -1;
            for (int c = 0; c < 150; c++) begin
                int cnt;
                int win;
                int rt;
                bit exp_full;
                bit exp_en;
                bit exp_ms;
                bit accept;
                longint ls, le, ss, se;
                clear_inputs();
                cnt = 0;
                for (int t = 0; t < 64; t++) cnt += int'(m_valid[t]);
                i_flush = ($urandom % 100) < 2;
                if (knext < 58 && ($urandom % 100) < 45) begin
                    i_alloc_en = 1;
                    i_alloc_tag = 6'((head + knext) % 64);
                    i_alloc_addr = 32'h100 + 32'($urandom % 16);
                    i_alloc_lsu_func = procyon_lsu_func_t'($urandom_range(0, 4));
                end
                i_replay_stall = ($urandom % 100) < 20;
                if (m_last >= 0 && m_valid[m_last] && ($urandom % 100) < 35) begin
                    i_update_lq_en = 1;
                    i_update_lq_retry = ($urandom % 4) == 0;
                    i_update_lq_mhq_tag = 2'($urandom % 4);
                end
                i_mhq_fill = ($urandom % 100) < 30;
                i_mhq_fill_tag = 2'($urandom % 4);
                if (($urandom % 100) < 25) begin
                    i_sq_retire_en = 1;
                    i_sq_retire_tag = 6'((head + int'($urandom % 60)) % 64);
                    i_sq_retire_addr = 32'h100 + 32'($urandom % 16);
                    i_sq_retire_lsu_func = procyon_lsu_func_t'($urandom_range(5, 7));
                end
                rt = (head + int'($urandom_range(0, knext))) % 64;
                i_rob_retire_tag = 6'(rt);
                i_rob_retire_en = m_valid[rt] && !m_nr[rt] && !(i_update_lq_en && rt == m_last) &&
                                  (($urandom % 100) < 30);

                win = -1;
                for (int t = 0; t < 64; t++) begin
                    if (m_valid[t] && m_rdy[t] && (win < 0 || age_of(t, head) < age_of(win, head))) win = t;
                end
                exp_full = (cnt == 8);
                exp_en = (win >= 0) && !i_replay_stall && !i_alloc_en;
                exp_ms = m_valid[rt] && m_ms[rt];

                @(negedge clk);
                n_tests++; if (o_full !== exp_full) begin n_fail++; $display("FAIL rnd_full ph%0d c%0d: got %0b expected %0b", ph, c, o_full, exp_full); end
                n_tests++; if (o_replay_en !== exp_en) begin n_fail++; $display("FAIL rnd_replay_en ph%0d c%0d: got %0b expected %0b", ph, c, o_replay_en, exp_en); end
                if (exp_en) begin
                    n_tests++; if (o_replay_tag !== 6'(win) || o_replay_addr !== m_addr[win] || o_replay_lsu_func !== m_func[win]) begin
                        n_fail++; $display("FAIL rnd_replay ph%0d c%0d: got tag=%0d addr=%0h func=%0d expected tag=%0d addr=%0h func=%0d",
                                           ph, c, o_replay_tag, o_replay_addr, o_replay_lsu_func, win, m_addr[win], m_func[win]);
                    end
                end
                n_tests++; if (o_rob_retire_mis_speculated !== exp_ms) begin n_fail++; $display("FAIL rnd_mis_spec ph%0d c%0d tag %0d: got %0b expected %0b", ph, c, rt, o_rob_retire_mis_speculated, exp_ms); end

                accept = i_alloc_en && !exp_full && !i_flush;
                for (int t = 0; t < 64; t++) begin
                    if (i_mhq_fill && m_nr[t] && !m_rdy[t] && (m_retry[t] || m_mhq[t] == i_mhq_fill_tag)) m_rdy[t] = 1;
                end
                if (i_sq_retire_en) begin
                    ss = longint'(i_sq_retire_addr);
                    se = ss + fsize(i_sq_retire_lsu_func);
                    for (int t = 0; t < 64; t++) begin
                        ls = longint'(m_addr[t]);
                        le = ls + fsize(m_func[t]);
                        if (m_valid[t] && !m_nr[t] && age_of(t, head) > age_of(int'(i_sq_retire_tag), head) &&
                            ls < se && ss < le) m_ms[t] = 1;
                    end
                end
                if (i_rob_retire_en) m_valid[rt] = 0;
                if (exp_en) begin m_nr[win] = 0; m_rdy[win] = 0; end
                if (i_update_lq_en) begin
                    m_nr[m_last] = 1;
                    m_retry[m_last] = i_update_lq_retry;
                    m_mhq[m_last] = i_update_lq_mhq_tag;
                    m_ms[m_last] = 0;
                    m_rdy[m_last] = i_mhq_fill && (i_update_lq_retry || i_mhq_fill_tag == i_update_lq_mhq_tag);
                end
                if (accept) begin
                    m_valid[i_alloc_tag] = 1; m_addr[i_alloc_tag] = i_alloc_addr;
                    m_func[i_alloc_tag] = i_alloc_lsu_func;
                    m_nr[i_alloc_tag] = 0; m_rdy[i_alloc_tag] = 0; m_ms[i_alloc_tag] = 0;
                    knext++;
                end
                if (i_flush) begin
                    for (int t = 0; t < 64; t++) begin m_valid[t] = 0; m_nr[t] = 0; m_rdy[t] = 0; end
                end
                if (accept) m_last = int'(i_alloc_tag);
                else if (exp_en) m_last = win;
                nxt();
            end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_replay_order();
        test_update_fill_race();
        test_mis_spec();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
